// File: rtl/ibuf_rdreq_mgmt.sv
// ibuf_rdreq_mgmt: splits host buffer descriptors into bounded memory read requests and
// commits the ibuff producer pointer in issue order as completions finish.
`timescale 1ns/1ps
module ibuf_rdreq_mgmt #(
  parameter int unsigned BW       = 9,
  parameter int unsigned TAG_W    = 5,
  parameter int unsigned MX_OS_RQ = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       cfg_max_rd_req_size,
  input  logic [63:0]      lbuf_addr,
  input  logic [31:0]      lbuf_len,
  input  logic             lbuf_en,
  output logic             lbuf_dn,
  input  logic [BW:0]      cons,
  output logic [BW:0]      committed_prod,
  output logic             rd,
  output logic [63:0]      hst_addr,
  output logic [9:0]       rd_qw,
  input  logic             rd_ack,
  input  logic [TAG_W-1:0] rd_tag,
  input  logic [TAG_W-1:0] cpl_tag,
  output logic [BW-1:0]    cpl_base,
  input  logic             cpl_vld,
  input  logic             cpl_last,
  output logic             err
);

  localparam int unsigned NTags = 1 << TAG_W;
  localparam int unsigned PtrW  = (MX_OS_RQ > 1) ? $clog2(MX_OS_RQ) : 1;
  localparam int unsigned CntW  = $clog2(MX_OS_RQ + 1);

  typedef logic [BW:0] ptr_t;

  typedef enum logic [2:0] {
    StIdle,
    StWaitOs,
    StCalc,
    StWaitSpace,
    StReq,
    StUpd,
    StDrain,
    StDone
  } state_e;

  state_e           state_q;
  logic [9:0]       mx_qw_q, mx_qw_d;
  logic [31:0]      left_q;
  logic [63:0]      addr_q;
  logic [9:0]       chunk_q, chunk_calc;
  logic             rd_q;
  logic             lbuf_dn_q;
  ptr_t             iprod_q;
  ptr_t             committed_q;
  logic             err_q;

  logic [TAG_W-1:0] fifo_q [MX_OS_RQ];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  os_cnt_q;
  logic [9:0]       len_q  [NTags];
  logic [BW-1:0]    base_q [NTags];
  logic [NTags-1:0] done_q;
  logic [NTags-1:0] outst_q;

  logic [TAG_W-1:0] head_tag;
  logic             commit;
  logic             push;
  logic             cpl_ok;
  logic             os_room;
  logic [9:0]       bnd_qw;
  ptr_t             used_qw;
  logic [BW+1:0]    free_qw;
  logic             space_ok;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    if (p == PtrW'(MX_OS_RQ - 1)) begin
      return '0;
    end
    return p + PtrW'(1);
  endfunction

  always_comb begin
    unique case (cfg_max_rd_req_size)
      3'd0:    mx_qw_d = 10'd16;
      3'd1:    mx_qw_d = 10'd32;
      3'd2:    mx_qw_d = 10'd64;
      3'd3:    mx_qw_d = 10'd128;
      3'd4:    mx_qw_d = 10'd256;
      default: mx_qw_d = 10'd512;
    endcase
  end

  // QWs left before the next 4 KB host boundary; address is QW aligned.
  assign bnd_qw = 10'd512 - {1'b0, addr_q[11:3]};

  always_comb begin
    chunk_calc = mx_qw_q;
    if (left_q < 32'(chunk_calc)) begin
      chunk_calc = left_q[9:0];
    end
    if (bnd_qw < chunk_calc) begin
      chunk_calc = bnd_qw;
    end
  end

  // Space is reserved against iprod so ibuff cannot overrun while completions are in flight.
  assign used_qw  = iprod_q - cons;
  assign free_qw  = {2'b01, {BW{1'b0}}} - {1'b0, used_qw};
  assign space_ok = 32'(chunk_q) <= 32'(free_qw);

  assign head_tag = fifo_q[rd_ptr_q];
  assign commit   = (os_cnt_q != '0) && done_q[head_tag];
  assign push     = (state_q == StReq) && rd_ack;
  assign cpl_ok   = outst_q[cpl_tag] && !done_q[cpl_tag];
  assign os_room  = os_cnt_q < CntW'(MX_OS_RQ);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      mx_qw_q   <= 10'd16;
      left_q    <= '0;
      addr_q    <= '0;
      chunk_q   <= '0;
      rd_q      <= 1'b0;
      lbuf_dn_q <= 1'b0;
      iprod_q   <= '0;
    end else begin
      mx_qw_q <= mx_qw_d;
      unique case (state_q)
        StIdle: begin
          addr_q <= lbuf_addr;
          left_q <= lbuf_len;
          if (lbuf_en) begin
            if (lbuf_len == '0) begin
              state_q   <= StDone;
              lbuf_dn_q <= 1'b1;
            end else begin
              state_q <= StWaitOs;
            end
          end
        end
        StWaitOs: begin
          if (os_room) begin
            state_q <= StCalc;
          end
        end
        StCalc: begin
          chunk_q <= chunk_calc;
          state_q <= StWaitSpace;
        end
        StWaitSpace: begin
          if (space_ok) begin
            rd_q    <= 1'b1;
            state_q <= StReq;
          end
        end
        StReq: begin
          if (rd_ack) begin
            rd_q    <= 1'b0;
            iprod_q <= iprod_q + ptr_t'(chunk_q);
            addr_q  <= addr_q + {51'b0, chunk_q, 3'b0};
            left_q  <= left_q - {22'b0, chunk_q};
            state_q <= StUpd;
          end
        end
        StUpd: begin
          state_q <= (left_q != '0) ? StWaitOs : StDrain;
        end
        StDrain: begin
          if (os_cnt_q == '0) begin
            state_q   <= StDone;
            lbuf_dn_q <= 1'b1;
          end
        end
        StDone: begin
          lbuf_dn_q <= 1'b0;
          state_q   <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fifo_q      <= '{default: '0};
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      os_cnt_q    <= '0;
      len_q       <= '{default: '0};
      base_q      <= '{default: '0};
      done_q      <= '0;
      outst_q     <= '0;
      committed_q <= '0;
      err_q       <= 1'b0;
    end else begin
      if (commit) begin
        committed_q       <= committed_q + ptr_t'(len_q[head_tag]);
        done_q[head_tag]  <= 1'b0;
        outst_q[head_tag] <= 1'b0;
        rd_ptr_q          <= ptr_inc(rd_ptr_q);
      end
      if (cpl_vld) begin
        if (!cpl_ok) begin
          err_q <= 1'b1;
        end else if (cpl_last) begin
          done_q[cpl_tag] <= 1'b1;
        end
      end
      // A freshly issued tag overrides any stale tracking for the same index.
      if (push) begin
        fifo_q[wr_ptr_q] <= rd_tag;
        wr_ptr_q         <= ptr_inc(wr_ptr_q);
        len_q[rd_tag]    <= chunk_q;
        base_q[rd_tag]   <= iprod_q[BW-1:0];
        outst_q[rd_tag]  <= 1'b1;
        done_q[rd_tag]   <= 1'b0;
      end
      if (push && !commit) begin
        os_cnt_q <= os_cnt_q + CntW'(1);
      end else if (!push && commit) begin
        os_cnt_q <= os_cnt_q - CntW'(1);
      end
    end
  end

  assign lbuf_dn        = lbuf_dn_q;
  assign committed_prod = committed_q;
  assign rd             = rd_q;
  assign hst_addr       = addr_q;
  assign rd_qw          = chunk_q;
  assign cpl_base       = base_q[cpl_tag];
  assign err            = err_q;

endmodule

// File: tb/tb_ibuf_rdreq_mgmt.sv
// Self-checking bench for ibuf_rdreq_mgmt: descriptor table, hand-written corner sequences
// and randomized descriptors against an arithmetic request/commit model.
`timescale 1ns/1ps
module tb_ibuf_rdreq_mgmt;
  localparam int unsigned BW       = 9;
  localparam int unsigned TAG_W    = 5;
  localparam int unsigned MX_OS_RQ = 4;
  localparam int unsigned PMOD     = 1 << (BW + 1);
  localparam int unsigned DEPTH    = 1 << BW;

  logic             clk = 1'b0;
  logic             rst;
  logic [2:0]       cfg_max_rd_req_size;
  logic [63:0]      lbuf_addr;
  logic [31:0]      lbuf_len;
  logic             lbuf_en;
  logic             lbuf_dn;
  logic [BW:0]      cons;
  logic [BW:0]      committed_prod;
  logic             rd;
  logic [63:0]      hst_addr;
  logic [9:0]       rd_qw;
  logic             rd_ack;
  logic [TAG_W-1:0] rd_tag;
  logic [TAG_W-1:0] cpl_tag;
  logic [BW-1:0]    cpl_base;
  logic             cpl_vld;
  logic             cpl_last;
  logic             err;

  always #5 clk = ~clk;

  ibuf_rdreq_mgmt #(.BW(BW), .TAG_W(TAG_W), .MX_OS_RQ(MX_OS_RQ)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .cfg_max_rd_req_size (cfg_max_rd_req_size),
    .lbuf_addr           (lbuf_addr),
    .lbuf_len            (lbuf_len),
    .lbuf_en             (lbuf_en),
    .lbuf_dn             (lbuf_dn),
    .cons                (cons),
    .committed_prod      (committed_prod),
    .rd                  (rd),
    .hst_addr            (hst_addr),
    .rd_qw               (rd_qw),
    .rd_ack              (rd_ack),
    .rd_tag              (rd_tag),
    .cpl_tag             (cpl_tag),
    .cpl_base            (cpl_base),
    .cpl_vld             (cpl_vld),
    .cpl_last            (cpl_last),
    .err                 (err)
  );

  typedef struct {
    int              cfg;
    longint unsigned addr;
    int              len;
    int              nreq;
    int              first_qw;
    int              last_qw;
    longint unsigned last_addr;
  } vec_t;

  int n_pass = 0;
  int n_total = 0;

  // Reference model state
  longint unsigned exp_addr_q[$];
  int              exp_qw_q[$];
  int unsigned     m_iprod;
  int unsigned     m_base[32];
  int              out_tags[$];
  int              forced_tags[$];
  int              next_tag;
  int              plan_n;
  int              rd_count, dn_count, first_qw, last_qw;
  longint unsigned last_addr;
  int              cpl_mode;
  bit              auto_ack, track_cons, lag_cons;

  task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  function automatic int mx_of(input int cfg);
    return (cfg <= 4) ? (16 << cfg) : 512;
  endfunction

  task automatic plan(input int cfg, input longint unsigned addr, input int len);
    longint unsigned a = addr;
    longint unsigned l = 64'(len);
    longint unsigned c;
    longint unsigned bnd;
    exp_addr_q.delete();
    exp_qw_q.delete();
    while (l > 0) begin
      bnd = (64'd4096 - (a % 64'd4096)) / 64'd8;
      c = 64'(mx_of(cfg));
      if (l < c) c = l;
      if (bnd < c) c = bnd;
      exp_addr_q.push_back(a);
      exp_qw_q.push_back(int'(c));
      a = a + c * 64'd8;
      l = l - c;
    end
    plan_n = exp_qw_q.size();
  endtask

  task automatic drive_cpl(input int tag, input bit last);
    cpl_tag  = TAG_W'(tag);
    cpl_vld  = 1'b1;
    cpl_last = last;
    #1;
    check("cpl_base", 64'(cpl_base), 64'(m_base[tag]));
  endtask

  task automatic complete_tag(input int tag);
    for (int i = 0; i < out_tags.size(); i++) begin
      if (out_tags[i] == tag) begin
        out_tags.delete(i);
        break;
      end
    end
    drive_cpl(tag, 1'b1);
  endtask

  task automatic accept();
    int tag;
    longint unsigned ea;
    int eq;
    if (forced_tags.size() > 0) tag = forced_tags.pop_front();
    else begin
      tag = next_tag;
      next_tag = (next_tag + 1) % 32;
    end
    rd_ack = 1'b1;
    rd_tag = TAG_W'(tag);
    rd_count++;
    if (rd_count == 1) first_qw = int'(rd_qw);
    last_qw   = int'(rd_qw);
    last_addr = hst_addr;
    if (exp_qw_q.size() == 0) begin
      n_total++;
      $display("FAIL rd_extra: got request of %0d QW at 0x%0h, required none", rd_qw, hst_addr);
    end else begin
      ea = exp_addr_q.pop_front();
      eq = exp_qw_q.pop_front();
      check("hst_addr", hst_addr, ea);
      check("rd_qw", 64'(rd_qw), 64'(eq));
      m_base[tag] = m_iprod % DEPTH;
      m_iprod = (m_iprod + int'(eq)) % PMOD;
    end
    out_tags.push_back(tag);
  endtask

  task automatic cycle();
    int r;
    @(posedge clk);
    #1;
    rd_ack   = 1'b0;
    cpl_vld  = 1'b0;
    cpl_last = 1'b0;
    if (lbuf_dn) dn_count++;
    if (track_cons && (!lag_cons || $urandom_range(0, 1) == 0)) cons = committed_prod;
    if (out_tags.size() > 0) begin
      if (cpl_mode == 1) complete_tag(out_tags[0]);
      else if (cpl_mode == 2) begin
        r = int'($urandom_range(0, 3));
        if (r < 2) complete_tag(out_tags[$urandom_range(0, out_tags.size() - 1)]);
        else if (r == 2) drive_cpl(out_tags[$urandom_range(0, out_tags.size() - 1)], 1'b0);
      end
    end
    if (auto_ack && rd) accept();
  endtask

  task automatic start_lbuf(input int cfg, input longint unsigned addr, input int len);
    rd_count = 0;
    dn_count = 0;
    first_qw = 0;
    last_qw  = 0;
    cfg_max_rd_req_size = 3'(cfg);
    cycle();
    plan(cfg, addr, len);
    lbuf_addr = addr;
    lbuf_len  = 32'(len);
    lbuf_en   = 1'b1;
    cycle();
    lbuf_en = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && dn_count == 0; i++) cycle();
    repeat (3) cycle();
  endtask

  task automatic wait_rd(input int n, input int budget);
    for (int i = 0; i < budget && rd_count < n; i++) cycle();
  endtask

  task automatic finish_checks(input string name, input int exp_n);
    check({name, "_dn_pulses"}, 64'(dn_count), 64'd1);
    check({name, "_rd_count"}, 64'(rd_count), 64'(exp_n));
    check({name, "_committed"}, 64'(committed_prod), 64'(m_iprod));
    check({name, "_err"}, 64'(err), 64'd0);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation still running, required self-termination");
    $fatal(1);
  end

  initial begin
    vec_t vecs[6];
    int unsigned c0;
    int cfg, len, n;
    longint unsigned addr;

    vecs[0] = '{0, 64'h1000, 40,   3, 16,  8,   64'h1100};
    vecs[1] = '{5, 64'h0F80, 600,  3, 16,  72,  64'h2000};
    vecs[2] = '{1, 64'h1FF8, 33,   2, 1,   32,  64'h2000};
    vecs[3] = '{3, 64'h3000, 128,  1, 128, 128, 64'h3000};
    vecs[4] = '{7, 64'h0000, 1024, 2, 512, 512, 64'h1000};
    vecs[5] = '{2, 64'h0FF0, 10,   2, 2,   8,   64'h1000};

    rst = 1'b0;
    cfg_max_rd_req_size = 3'd0;
    lbuf_addr = '0;
    lbuf_len  = '0;
    lbuf_en   = 1'b0;
    cons      = '0;
    rd_ack    = 1'b0;
    rd_tag    = '0;
    cpl_tag   = '0;
    cpl_vld   = 1'b0;
    cpl_last  = 1'b0;
    m_iprod   = 0;
    next_tag  = int'($urandom_range(0, 31));
    cpl_mode  = 1;
    auto_ack  = 1'b1;
    track_cons = 1'b1;
    lag_cons  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rd", 64'(rd), 64'd0);
    check("rst_lbuf_dn", 64'(lbuf_dn), 64'd0);
    check("rst_committed", 64'(committed_prod), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_hst_addr", hst_addr, 64'd0);
    check("rst_rd_qw", 64'(rd_qw), 64'd0);
    check("rst_cpl_base", 64'(cpl_base), 64'd0);
    rst = 1'b1;
    cycle();

    // Descriptor table, in-order completions, cons following committed_prod
    for (int i = 0; i < 6; i++) begin
      c0 = m_iprod;
      start_lbuf(vecs[i].cfg, vecs[i].addr, vecs[i].len);
      wait_done(2000);
      check($sformatf("vec%0d_nreq", i), 64'(rd_count), 64'(vecs[i].nreq));
      check($sformatf("vec%0d_first_qw", i), 64'(first_qw), 64'(vecs[i].first_qw));
      check($sformatf("vec%0d_last_qw", i), 64'(last_qw), 64'(vecs[i].last_qw));
      check($sformatf("vec%0d_last_addr", i), last_addr, vecs[i].last_addr);
      check($sformatf("vec%0d_commit_delta", i), 64'(committed_prod),
            64'((c0 + 32'(vecs[i].len)) % PMOD));
      finish_checks($sformatf("vec%0d", i), vecs[i].nreq);
    end

    // Out-of-order completions: tags 3,7,1,2 complete as 2,1,7,3
    cpl_mode = 0;
    forced_tags = '{3, 7, 1, 2};
    c0 = m_iprod;
    start_lbuf(0, 64'h4000, 64);
    wait_rd(4, 80);
    cycle();
    complete_tag(2);
    cycle();
    complete_tag(1);
    cycle();
    complete_tag(7);
    repeat (3) cycle();
    check("ooo_hold", 64'(committed_prod), 64'(c0));
    complete_tag(3);
    cycle();
    for (int k = 0; k < 5; k++) begin
      check($sformatf("ooo_step%0d", k), 64'(committed_prod), 64'((c0 + 16 * k) % PMOD));
      cycle();
    end
    wait_done(50);
    finish_checks("ooo", 4);

    // Outstanding limit: completions withheld
    cpl_mode = 0;
    start_lbuf(0, 64'h0, 96);
    repeat (40) cycle();
    check("os_limit_rd_count", 64'(rd_count), 64'(MX_OS_RQ));
    check("os_limit_rd_low", 64'(rd), 64'd0);
    complete_tag(out_tags[0]);
    wait_rd(5, 20);
    check("os_release_5th", 64'(rd_count), 64'd5);
    cpl_mode = 1;
    wait_done(400);
    finish_checks("os_limit", 6);

    // ibuff space stall with cons held back
    track_cons = 1'b0;
    cons = (BW+1)'(m_iprod);
    start_lbuf(4, 64'h0, 1024);
    repeat (60) cycle();
    check("space_stall_count", 64'(rd_count), 64'd2);
    check("space_stall_rd_low", 64'(rd), 64'd0);
    cons = cons + (BW+1)'(256);
    wait_rd(3, 30);
    check("space_release", 64'(rd_count), 64'd3);
    track_cons = 1'b1;
    wait_done(600);
    finish_checks("space", 4);

    // Randomized descriptors, random completion order, lagging consumer
    cpl_mode = 2;
    lag_cons = 1'b1;
    for (int i = 0; i < 12; i++) begin
      cfg  = int'($urandom_range(0, 7));
      addr = {32'($urandom), 32'($urandom)} & ~64'h7;
      len  = int'($urandom_range(0, 1500));
      start_lbuf(cfg, addr, len);
      n = plan_n;
      wait_done(8000);
      finish_checks($sformatf("rand%0d", i), n);
    end
    lag_cons = 1'b0;

    // Duplicate final completion raises err
    cpl_mode = 0;
    start_lbuf(0, 64'h0, 16);
    wait_rd(1, 30);
    cycle();
    n = out_tags[0];
    complete_tag(n);
    cycle();
    check("err_before_dup", 64'(err), 64'd0);
    cpl_tag  = TAG_W'(n);
    cpl_vld  = 1'b1;
    cpl_last = 1'b1;
    cycle();
    check("dup_cpl_err", 64'(err), 64'd1);
    wait_done(50);
    check("dup_dn_pulses", 64'(dn_count), 64'd1);
    check("dup_committed", 64'(committed_prod), 64'(m_iprod));

    // Reset while a request is pending
    auto_ack = 1'b0;
    cpl_mode = 1;
    start_lbuf(0, 64'h2000, 32);
    for (int i = 0; i < 30 && !rd; i++) cycle();
    check("pre_rst_rd", 64'(rd), 64'd1);
    rst = 1'b0;
    #1;
    check("midrst_rd", 64'(rd), 64'd0);
    check("midrst_lbuf_dn", 64'(lbuf_dn), 64'd0);
    check("midrst_committed", 64'(committed_prod), 64'd0);
    check("midrst_err", 64'(err), 64'd0);
    m_iprod = 0;
    out_tags.delete();
    forced_tags.delete();
    exp_addr_q.delete();
    exp_qw_q.delete();
    cycle();
    rst = 1'b1;
    auto_ack = 1'b1;
    cycle();
    cpl_tag  = TAG_W'(n);
    cpl_vld  = 1'b1;
    cpl_last = 1'b1;
    cycle();
    cycle();
    check("late_cpl_err", 64'(err), 64'd1);

    // Zero-length descriptor: lbuf_dn with no request
    start_lbuf(0, 64'h40, 0);
    repeat (4) cycle();
    check("zero_len_dn", 64'(dn_count), 64'd1);
    check("zero_len_no_rd", 64'(rd_count), 64'd0);
    check("zero_len_committed", 64'(committed_prod), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
